// File: rtl/game_pkg.sv
// Shared constants for the game score controller: FSM encoding and 7-segment patterns.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active low.
package game_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PLAY      = 2'd1;
    localparam logic [1:0] ST_LOSE_WAIT = 2'd2;
    localparam logic [1:0] ST_OVER      = 2'd3;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [7:0] SEG_DASH   = 8'hBF;
    localparam logic [7:0] SEG_DP_ON  = 8'h7F;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-time debounce, and a
// one-cycle pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk_25M_reg,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synced input disagrees with the accepted level,
    // so any bounce back to the old level restarts the stable window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        pulse_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25M_reg or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/game_score_ctrl.sv
// Game state machine for the ball/bar display: BCD score, lives, bar speed,
// and a multiplexed 4-digit 7-segment scan of the score.
module game_score_ctrl
    import game_pkg::*;
#(
    parameter int LIVES      = 3,
    parameter int DEB_CYCLES = 250000,
    parameter int SCAN_DIV   = 12500,
    parameter int SPEED_BASE = 2,
    parameter int SPEED_MAX  = 8,
    parameter int STEP_HITS  = 5
) (
    input  logic        clk_25M_reg,
    input  logic        rst_n,
    input  logic        get,
    input  logic        lose,
    input  logic        start_btn,
    output logic [3:0]  bar_move_speed,
    output logic        game_run,
    output logic        game_over,
    output logic [1:0]  lives,
    output logic [15:0] score_bcd,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int HW = $clog2(STEP_HITS + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);

    function automatic logic [15:0] bcd_inc_sat(input logic [15:0] s);
        logic [15:0] r;
        logic        c;
        r = s;
        c = 1'b1;
        if (s != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (c) begin
                    if (s[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = s[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] speed_inc_sat(input logic [3:0] v);
        return (v >= 4'(SPEED_MAX)) ? 4'(SPEED_MAX) : v + 4'd1;
    endfunction

    logic [2:0]    get_sync_q, lose_sync_q;
    logic          get_p_q, lose_p_q;
    logic          lose_s;
    logic          start_p, start_lvl;

    logic [1:0]    state_q, state_d;
    logic [15:0]   score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic [HW-1:0] hit_q, hit_d;
    logic [3:0]    speed_q, speed_d;
    logic          run_q, over_q;
    logic [3:0]    spd_out_q;

    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    dig_q, dig_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_start_deb (
        .clk_25M_reg(clk_25M_reg),
        .rst_n      (rst_n),
        .btn_i      (start_btn),
        .level_o    (start_lvl),
        .pulse_o    (start_p)
    );

    assign lose_s = lose_sync_q[1];

    // Input synchronizers; the third stage holds the previous synced level for edge detect.
    always_ff @(posedge clk_25M_reg or negedge rst_n) begin
        if (!rst_n) begin
            get_sync_q  <= '0;
            lose_sync_q <= '0;
            get_p_q     <= 1'b0;
            lose_p_q    <= 1'b0;
        end else begin
            get_sync_q  <= {get_sync_q[1:0], get};
            lose_sync_q <= {lose_sync_q[1:0], lose};
            get_p_q     <= get_sync_q[1] & ~get_sync_q[2];
            lose_p_q    <= lose_sync_q[1] & ~lose_sync_q[2];
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        hit_d   = hit_q;
        speed_d = speed_q;
        case (state_q)
            ST_IDLE: begin
                if (start_p) begin
                    score_d = '0;
                    lives_d = 2'(LIVES);
                    hit_d   = '0;
                    speed_d = 4'(SPEED_BASE);
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (lose_p_q) begin
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q <= 2'd1) ? ST_OVER : ST_LOSE_WAIT;
                end else if (get_p_q) begin
                    score_d = bcd_inc_sat(score_q);
                    if (hit_q == HW'(STEP_HITS - 1)) begin
                        hit_d   = '0;
                        speed_d = speed_inc_sat(speed_q);
                    end else begin
                        hit_d = hit_q + 1'b1;
                    end
                end
            end
            ST_LOSE_WAIT: begin
                if (!lose_s) state_d = ST_PLAY;
            end
            default: begin
                if (start_p) state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decode the next state so they change together with state_q.
    always_ff @(posedge clk_25M_reg or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            score_q   <= '0;
            lives_q   <= 2'(LIVES);
            hit_q     <= '0;
            speed_q   <= '0;
            run_q     <= 1'b0;
            over_q    <= 1'b0;
            spd_out_q <= '0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            hit_q     <= hit_d;
            speed_q   <= speed_d;
            run_q     <= (state_d == ST_PLAY);
            over_q    <= (state_d == ST_OVER);
            spd_out_q <= (state_d == ST_PLAY || state_d == ST_LOSE_WAIT) ? speed_d : 4'd0;
        end
    end

    always_comb begin
        scan_d = scan_q + 1'b1;
        dig_d  = dig_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            dig_d  = dig_q + 2'd1;
        end
        an_d = ~(4'b0001 << dig_q);
        if (state_q == ST_IDLE) begin
            seg_d = SEG_DASH;
        end else begin
            seg_d = seg_digit(score_q[4*dig_q +: 4]);
        end
        if (state_q == ST_OVER) seg_d = seg_d & SEG_DP_ON;
    end

    always_ff @(posedge clk_25M_reg or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
            dig_q  <= '0;
            seg_q  <= SEG_BLANK;
            an_q   <= 4'b1110;
        end else begin
            scan_q <= scan_d;
            dig_q  <= dig_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign bar_move_speed = spd_out_q;
    assign game_run       = run_q;
    assign game_over      = over_q;
    assign lives          = lives_q;
    assign score_bcd      = score_q;
    assign seg            = seg_q;
    assign an             = an_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Directed bench for game_score_ctrl with a score scoreboard: every expected
// score change is queued when stimulus is driven and popped when the score moves.
module tb_game_score_ctrl;

    localparam int DEB   = 16;
    localparam int SCAN  = 4;
    localparam int LIV   = 3;
    localparam int BASE  = 2;
    localparam int SMAX  = 8;
    localparam int STEP  = 5;

    logic        clk_25M_reg = 1'b0;
    logic        rst_n;
    logic        get, lose, start_btn;
    logic [3:0]  bar_move_speed;
    logic        game_run, game_over;
    logic [1:0]  lives;
    logic [15:0] score_bcd;
    logic [7:0]  seg;
    logic [3:0]  an;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] prev_score;
    logic [15:0] e;
    bit          mon_en = 1'b0;

    int          mscore, mhits, mlives;

    game_score_ctrl #(
        .LIVES(LIV), .DEB_CYCLES(DEB), .SCAN_DIV(SCAN),
        .SPEED_BASE(BASE), .SPEED_MAX(SMAX), .STEP_HITS(STEP)
    ) dut (
        .clk_25M_reg   (clk_25M_reg),
        .rst_n         (rst_n),
        .get           (get),
        .lose          (lose),
        .start_btn     (start_btn),
        .bar_move_speed(bar_move_speed),
        .game_run      (game_run),
        .game_over     (game_over),
        .lives         (lives),
        .score_bcd     (score_bcd),
        .seg           (seg),
        .an            (an)
    );

    always #5 clk_25M_reg = ~clk_25M_reg;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic int exp_speed();
        int s;
        s = BASE + mhits / STEP;
        return (s > SMAX) ? SMAX : s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_25M_reg);
    endtask

    task automatic hit(input bit counted);
        @(negedge clk_25M_reg);
        get = 1'b1;
        if (counted) begin
            if (mscore < 9999) begin
                mscore++;
                exp_q.push_back(to_bcd(mscore));
            end
            mhits++;
        end
        @(negedge clk_25M_reg);
        get = 1'b0;
    endtask

    task automatic press_start();
        @(negedge clk_25M_reg);
        start_btn = 1'b1;
        cyc(DEB + 14);
        start_btn = 1'b0;
        cyc(DEB + 14);
    endtask

    task automatic lose_event();
        @(negedge clk_25M_reg);
        lose = 1'b1;
        mlives--;
        cyc(8);
        lose = 1'b0;
        cyc(8);
    endtask

    // Scoreboard monitor: each score movement must match the oldest queued expectation.
    always @(posedge clk_25M_reg) begin
        #1;
        if (mon_en && (score_bcd !== prev_score)) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL score_unexpected observed=%h expected=no_change", score_bcd);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                assert (score_bcd === e) else begin
                    bad++;
                    $error("FAIL score_sb observed=%h expected=%h", score_bcd, e);
                end
            end
        end
        prev_score = score_bcd;
    end

    initial begin
        logic [3:0] seen;
        bit         oh_bad;
        rst_n = 1'b0; get = 1'b0; lose = 1'b0; start_btn = 1'b0;
        mscore = 0; mhits = 0; mlives = LIV;
        cyc(3);
        chk("rst_score", 32'(score_bcd), 32'h0);
        chk("rst_lives", 32'(lives), 32'(LIV));
        chk("rst_speed", 32'(bar_move_speed), 32'h0);
        chk("rst_an", 32'(an), 32'hE);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_run", 32'(game_run), 32'h0);
        chk("rst_over", 32'(game_over), 32'h0);
        rst_n = 1'b1;
        cyc(3);
        mon_en = 1'b1;
        chk("idle_seg_dash", 32'(seg), 32'hBF);

        seen = '0; oh_bad = 1'b0;
        repeat (4 * SCAN + 4) begin
            @(negedge clk_25M_reg);
            case (an)
                4'b1110: seen[0] = 1'b1;
                4'b1101: seen[1] = 1'b1;
                4'b1011: seen[2] = 1'b1;
                4'b0111: seen[3] = 1'b1;
                default: oh_bad = 1'b1;
            endcase
        end
        chk("an_all_digits", 32'(seen), 32'hF);
        chk("an_onehot", 32'(oh_bad), 32'h0);

        repeat (3) begin
            @(negedge clk_25M_reg);
            start_btn = 1'b1;
            cyc(DEB - 6);
            start_btn = 1'b0;
            cyc(3);
        end
        cyc(2 * DEB);
        chk("bounce_no_start", 32'(game_run), 32'h0);

        press_start();
        chk("start_run", 32'(game_run), 32'h1);
        chk("start_speed", 32'(bar_move_speed), 32'(BASE));
        chk("start_lives", 32'(lives), 32'(LIV));

        repeat (12) hit(1'b1);
        cyc(6);
        chk("score_12", 32'(score_bcd), 32'h0012);
        chk("speed_12", 32'(bar_move_speed), 32'(exp_speed()));

        @(negedge clk_25M_reg);
        get = 1'b1;
        mscore++; mhits++;
        exp_q.push_back(to_bcd(mscore));
        cyc(40);
        get = 1'b0;
        cyc(6);
        chk("held_get_once", 32'(score_bcd), 32'h0013);

        press_start();
        chk("start_in_play_ignored", 32'(game_run), 32'h1);

        @(negedge clk_25M_reg);
        get = 1'b1; lose = 1'b1;
        mlives--;
        @(negedge clk_25M_reg);
        get = 1'b0;
        cyc(6);
        chk("both_lives", 32'(lives), 32'(mlives));
        chk("both_score", 32'(score_bcd), 32'h0013);
        chk("lose_wait_run", 32'(game_run), 32'h0);
        chk("lose_wait_over", 32'(game_over), 32'h0);
        chk("lose_wait_speed", 32'(bar_move_speed), 32'(exp_speed()));
        hit(1'b0);
        cyc(6);
        chk("lose_wait_get_ignored", 32'(score_bcd), 32'h0013);
        lose = 1'b0;
        cyc(6);
        chk("back_to_play", 32'(game_run), 32'h1);

        while (mscore < 999) hit(1'b1);
        cyc(6);
        chk("score_0999", 32'(score_bcd), 32'h0999);
        hit(1'b1);
        cyc(6);
        chk("score_1000", 32'(score_bcd), 32'h1000);
        while (mscore < 9999) hit(1'b1);
        cyc(6);
        chk("score_9999", 32'(score_bcd), 32'h9999);
        hit(1'b1);
        cyc(6);
        chk("score_sat", 32'(score_bcd), 32'h9999);
        chk("speed_cap", 32'(bar_move_speed), 32'(SMAX));

        lose_event();
        chk("lives_1", 32'(lives), 32'(mlives));
        chk("still_play", 32'(game_run), 32'h1);
        lose_event();
        chk("lives_0", 32'(lives), 32'h0);
        chk("over_flag", 32'(game_over), 32'h1);
        chk("over_run", 32'(game_run), 32'h0);
        chk("over_speed", 32'(bar_move_speed), 32'h0);
        chk("over_seg_dp", 32'(seg), 32'h10);
        cyc(SCAN + 1);
        chk("over_seg_dp_next", 32'(seg), 32'h10);
        hit(1'b0);
        cyc(6);
        chk("over_score_frozen", 32'(score_bcd), 32'h9999);

        press_start();
        chk("idle_over_flag", 32'(game_over), 32'h0);
        chk("idle_run", 32'(game_run), 32'h0);
        chk("idle_score_kept", 32'(score_bcd), 32'h9999);
        chk("idle_dash", 32'(seg), 32'hBF);

        exp_q.push_back(16'h0000);
        mscore = 0; mhits = 0; mlives = LIV;
        press_start();
        chk("restart_lives", 32'(lives), 32'(LIV));
        chk("restart_speed", 32'(bar_move_speed), 32'(BASE));
        repeat (3) hit(1'b1);
        cyc(6);
        chk("restart_score", 32'(score_bcd), 32'h0003);

        exp_q.push_back(16'h0000);
        @(negedge clk_25M_reg);
        rst_n = 1'b0;
        #1;
        chk("midrst_run", 32'(game_run), 32'h0);
        chk("midrst_score", 32'(score_bcd), 32'h0);
        chk("midrst_lives", 32'(lives), 32'(LIV));
        chk("midrst_speed", 32'(bar_move_speed), 32'h0);
        chk("midrst_an", 32'(an), 32'hE);
        chk("midrst_seg", 32'(seg), 32'hFF);
        cyc(3);
        rst_n = 1'b1;
        cyc(6);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_score_ctrl.md
Name: game_score_ctrl

Overview:
Downstream of the VGA ball/bar display. Consumes its `get` (bar hit) and `lose` (ball dropped) levels and keeps a 4-digit BCD score and a lives count. Runs the game state machine and drives `bar_move_speed` back into the display. Scans the score onto a 4-digit 7-segment display.

Parameters:
LIVES, 3, lives at game start (1..3)
DEB_CYCLES, 250000, start-button stable time in clk cycles (10 ms at 25 MHz)
SCAN_DIV, 12500, clk cycles per 7-seg digit slot (0.5 ms)
SPEED_BASE, 2, bar_move_speed at game start
SPEED_MAX, 8, saturation value of bar_move_speed
STEP_HITS, 5, hits per speed increment

Ports:
clk_25M_reg  in  1  25 MHz pixel clock; all logic on its rising edge
rst_n  in  1  asynchronous, active-low reset
get  in  1  level from display, high after bar bounce
lose  in  1  level from display, high after ball drop
start_btn  in  1  raw push button, active high
bar_move_speed  out  4  speed to display
game_run  out  1  high only in PLAY
game_over  out  1  high only in OVER
lives  out  2  remaining lives
score_bcd  out  16  4 BCD digits, [15:12] = thousands
seg  out  8  segments {dp,g,f,e,d,c,b,a}, active low
an  out  4  digit enables, active low, one-hot

Behaviour:
- Reset values (async, on rst_n low):
  - state = IDLE, score_bcd = 0, lives = LIVES, bar_move_speed = 0
  - game_run = 0, game_over = 0, an = 4'b1110, seg = 8'hFF
  - all internal counters cleared
- Input conditioning:
  - `get` and `lose` pass through 2-FF synchronizers, then rising-edge detect into get_p / lose_p (1-cycle pulses).
  - Latency from input edge to pulse is 3 cycles.
- start_btn path:
  - 2-FF sync, then debounce: the counter resets on any change and the new level is accepted after DEB_CYCLES stable cycles.
  - start_p is a 1-cycle pulse on the accepted rising edge.
- FSM states: IDLE, PLAY, LOSE_WAIT, OVER.
  - IDLE: on start_p, load score = 0, lives = LIVES, hit_cnt = 0, speed = SPEED_BASE, then go to PLAY.
  - PLAY, lose_p: lives decrements. If lives was 1, lives goes to 0 and the state goes to OVER; otherwise the state goes to LOSE_WAIT.
  - PLAY, get_p without lose_p: score += 1 (BCD).
  - PLAY, get_p and lose_p in the same cycle: lose wins and the score is unchanged.
  - LOSE_WAIT: ignore get_p. Return to PLAY when synced lose is low (the display clears lose when the ball reaches the top).
  - OVER: score and lives frozen. start_p goes to IDLE. Score is retained until the next IDLE→PLAY load.
  - start_p in PLAY or LOSE_WAIT is ignored.
- Score arithmetic:
  - BCD ripple increment; a digit at 9 goes to 0 with carry.
  - Saturates at 9999: a further get_p leaves 9999.
- Speed:
  - On each counted hit, hit_cnt increments.
  - When hit_cnt reaches STEP_HITS-1, it wraps to 0 and speed = min(speed+1, SPEED_MAX).
  - bar_move_speed = speed in PLAY and LOSE_WAIT, and 0 in IDLE and OVER (display frozen).
- Outputs: game_run and game_over are registered and decode state in the same cycle the state register updates.
- 7-seg scan:
  - scan_cnt counts 0..SCAN_DIV-1. On wrap, digit index advances 0→1→2→3→0 with an = 1110, 1101, 1011, 0111.
  - seg is registered from the selected score digit, standard hex decode for 0-9, no leading-zero blanking, dp off.
  - In IDLE every digit shows '-' (seg = 8'hBF).
  - In OVER, dp is lit on all digits.
  - BCD codes above 9 never occur; their decode is blank (8'hFF).

Decomposition:
- Shared package game_pkg:
  - FSM state encoding (2-bit localparams)
  - 7-seg constants: SEG_BLANK, SEG_DASH, digit lookup 0-9
  - reuse of the existing game `define direction macros is not needed
- Sub-module `btn_debounce` (sync + stable counter + rising pulse), parameterised by DEB_CYCLES. It is reusable for future left/right buttons.
- The rest is a single module.

Test Plan:
- Reset with rst_n low → score_bcd = 0, lives = 3, bar_move_speed = 0, an = 1110, seg = BF after first digit update; release and wait → state IDLE.
- start_btn held high 260000 cycles → game_run = 1, bar_move_speed = 2. Bounce pulses shorter than 250000 cycles → no start.
- PLAY, 12 get rising edges → score_bcd = 16'h0012, bar_move_speed = 4 (steps at hits 5 and 10). Holding get high for many cycles counts once.
- Score preset near 0999 via 999+1 hits → 16'h1000. At 9999, one more get → stays 9999. After 30 hits speed caps at 8.
- get and lose rising in the same cycle → score unchanged, lives 3→2, state LOSE_WAIT; a get pulse during LOSE_WAIT is not counted; lose low → PLAY.
- Three lose events → lives = 0, game_over = 1, bar_move_speed = 0, dp lit. start → IDLE with dashes. Assert rst_n mid-PLAY → immediate reset values.
